addsub_pipeline_sat: RTL and testbench

Parametrised pipelined adder/subtractor that splits the carry chain into registered slices, one slice per stage, so the retiming flow has balanced stages to work on. Each transaction selects add or subtract, signed or unsigned interpretation, and wrap or saturate. A valid/ready handshake on both sides lets downstream logic stall the pipeline without losing data.

---
 rtl/addsub_pipeline_sat_if.sv | 27 ++
 rtl/addsub_pipeline_sat.sv | 144 ++++++++++++++
 tb/tb_addsub_pipeline_sat.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipeline_sat_if.sv
// Operand/result bundle with valid/ready handshakes on both sides of the adder pipeline.
interface addsub_pipeline_sat_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] A;
  logic [DATAWIDTH-1:0] B;
  logic                 op;
  logic                 is_signed;
  logic                 sat;
  logic                 i_valid;
  logic                 i_ready;
  logic [DATAWIDTH-1:0] Result;
  logic                 Carry;
  logic                 Overflow;
  logic                 o_valid;
  logic                 o_ready;

  modport master (
    output A, B, op, is_signed, sat, i_valid, o_ready,
    input  i_ready, Result, Carry, Overflow, o_valid
  );

  modport slave (
    input  A, B, op, is_signed, sat, i_valid, o_ready,
    output i_ready, Result, Carry, Overflow, o_valid
  );
endinterface

// File: rtl/addsub_pipeline_sat.sv
// Pipelined add/subtract: the carry chain is cut into S-1 registered slices,
// followed by one stage that derives the flags and applies saturation.
module addsub_pipeline_sat #(
  parameter int DATAWIDTH           = 8,
  parameter int NUM_PIPELINE_STAGES = 4
) (
  input logic                  clk,
  input logic                  rst,
  addsub_pipeline_sat_if.slave bus
);
  localparam int N = DATAWIDTH;
  localparam int L = NUM_PIPELINE_STAGES - 1;
  localparam int W = (N + L - 1) / L;

  localparam int CV  = 5;
  localparam int COP = 4;
  localparam int CSG = 3;
  localparam int CST = 2;
  localparam int CAM = 1;
  localparam int CBM = 0;

  logic en;
  assign en = bus.o_ready || !bus.o_valid;

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : stg
      localparam int BASE = gi * W;
      localparam int SRCW = (N > BASE) ? (N - BASE) : 0;
      localparam int SW   = (SRCW > W) ? W : SRCW;
      localparam int NB   = SRCW - SW;

      // x holds finished sum bits below BASE and untouched A bits above it
      logic [N-1:0] x_src, x_next, x_reg;
      logic         c_src, c_next, c_reg;
      logic [5:0]   ctl_src, ctl_reg;

      if (gi == 0) begin : head
        assign x_src   = bus.A;
        assign c_src   = bus.op;
        assign ctl_src = {bus.i_valid, bus.op, bus.is_signed, bus.sat,
                          bus.A[N-1], bus.B[N-1] ^ bus.op};
      end else begin : tail
        assign x_src   = stg[gi-1].x_reg;
        assign c_src   = stg[gi-1].c_reg;
        assign ctl_src = stg[gi-1].ctl_reg;
      end

      if (SW > 0) begin : slc
        logic [SRCW-1:0] b_src;
        logic [SW:0]     psum;

        if (gi == 0) begin : bhead
          assign b_src = bus.B ^ {N{bus.op}};
        end else begin : btail
          assign b_src = stg[gi-1].slc.fwd.b_reg;
        end

        assign psum = {1'b0, x_src[BASE +: SW]} + {1'b0, b_src[SW-1:0]}
                    + {{SW{1'b0}}, c_src};

        always_comb begin
          x_next              = x_src;
          x_next[BASE +: SW]  = psum[SW-1:0];
        end
        assign c_next = psum[SW];

        // Only the still-unprocessed upper bits of B travel to later stages
        if (NB > 0) begin : fwd
          logic [NB-1:0] b_reg;
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              b_reg <= '0;
            end else if (en) begin
              b_reg <= b_src[SRCW-1:SW];
            end
          end
        end
      end else begin : pass
        assign x_next = x_src;
        assign c_next = c_src;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          x_reg   <= '0;
          c_reg   <= 1'b0;
          ctl_reg <= '0;
        end else if (en) begin
          x_reg   <= x_next;
          c_reg   <= c_next;
          ctl_reg <= ctl_src;
        end
      end
    end
  endgenerate

  logic [N-1:0] sum_f;
  logic         cout_f;
  logic [5:0]   ctl_f;
  logic [N-1:0] result_next, result_reg;
  logic         ovf_next, ovf_reg, carry_reg, o_valid_reg;

  assign sum_f  = stg[L-1].x_reg;
  assign cout_f = stg[L-1].c_reg;
  assign ctl_f  = stg[L-1].ctl_reg;

  always_comb begin
    if (ctl_f[CSG]) begin
      ovf_next = (ctl_f[CAM] == ctl_f[CBM]) && (sum_f[N-1] != ctl_f[CAM]);
    end else begin
      // unsigned subtract overflows when there is a borrow, i.e. no carry
      ovf_next = ctl_f[COP] ? !cout_f : cout_f;
    end
    result_next = sum_f;
    if (ctl_f[CST] && ovf_next) begin
      if (ctl_f[CSG]) begin
        result_next = ctl_f[CAM] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end else begin
        result_next = ctl_f[COP] ? '0 : '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_reg  <= '0;
      carry_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      o_valid_reg <= 1'b0;
    end else if (en) begin
      result_reg  <= result_next;
      carry_reg   <= cout_f;
      ovf_reg     <= ovf_next;
      o_valid_reg <= ctl_f[CV];
    end
  end

  assign bus.i_ready  = en;
  assign bus.Result   = result_reg;
  assign bus.Carry    = carry_reg;
  assign bus.Overflow = ovf_reg;
  assign bus.o_valid  = o_valid_reg;
endmodule

// File: tb/tb_addsub_pipeline_sat.sv
// Bench for addsub_pipeline_sat: directed corner cases on an 8-bit/4-stage
// instance plus random handshake traffic on several parameter sets.
module tb_addsub_pipeline_sat;
  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  // index 0: N=8 S=4, 1: N=8 S=2, 2: N=13 S=5, 3: N=3 S=6
  logic [15:0] g_a [4];
  logic [15:0] g_b [4];
  logic        g_op [4];
  logic        g_sg [4];
  logic        g_sat [4];
  logic        g_iv [4];
  logic        g_or [4];
  logic        g_ir [4];
  logic [15:0] g_res [4];
  logic        g_c [4];
  logic        g_ovf [4];
  logic        g_ov [4];

  addsub_pipeline_sat_if #(.DATAWIDTH(8))  if0 ();
  addsub_pipeline_sat_if #(.DATAWIDTH(8))  if1 ();
  addsub_pipeline_sat_if #(.DATAWIDTH(13)) if2 ();
  addsub_pipeline_sat_if #(.DATAWIDTH(3))  if3 ();

  addsub_pipeline_sat #(.DATAWIDTH(8),  .NUM_PIPELINE_STAGES(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  addsub_pipeline_sat #(.DATAWIDTH(8),  .NUM_PIPELINE_STAGES(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  addsub_pipeline_sat #(.DATAWIDTH(13), .NUM_PIPELINE_STAGES(5)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  addsub_pipeline_sat #(.DATAWIDTH(3),  .NUM_PIPELINE_STAGES(6)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.A = g_a[0][7:0];   assign if0.B = g_b[0][7:0];
  assign if1.A = g_a[1][7:0];   assign if1.B = g_b[1][7:0];
  assign if2.A = g_a[2][12:0];  assign if2.B = g_b[2][12:0];
  assign if3.A = g_a[3][2:0];   assign if3.B = g_b[3][2:0];
  assign if0.op = g_op[0]; assign if0.is_signed = g_sg[0]; assign if0.sat = g_sat[0];
  assign if1.op = g_op[1]; assign if1.is_signed = g_sg[1]; assign if1.sat = g_sat[1];
  assign if2.op = g_op[2]; assign if2.is_signed = g_sg[2]; assign if2.sat = g_sat[2];
  assign if3.op = g_op[3]; assign if3.is_signed = g_sg[3]; assign if3.sat = g_sat[3];
  assign if0.i_valid = g_iv[0]; assign if0.o_ready = g_or[0];
  assign if1.i_valid = g_iv[1]; assign if1.o_ready = g_or[1];
  assign if2.i_valid = g_iv[2]; assign if2.o_ready = g_or[2];
  assign if3.i_valid = g_iv[3]; assign if3.o_ready = g_or[3];
  assign g_ir[0] = if0.i_ready; assign g_ov[0] = if0.o_valid;
  assign g_ir[1] = if1.i_ready; assign g_ov[1] = if1.o_valid;
  assign g_ir[2] = if2.i_ready; assign g_ov[2] = if2.o_valid;
  assign g_ir[3] = if3.i_ready; assign g_ov[3] = if3.o_valid;
  assign g_res[0] = {8'd0, if0.Result};  assign g_c[0] = if0.Carry; assign g_ovf[0] = if0.Overflow;
  assign g_res[1] = {8'd0, if1.Result};  assign g_c[1] = if1.Carry; assign g_ovf[1] = if1.Overflow;
  assign g_res[2] = {3'd0, if2.Result};  assign g_c[2] = if2.Carry; assign g_ovf[2] = if2.Overflow;
  assign g_res[3] = {13'd0, if3.Result}; assign g_c[3] = if3.Carry; assign g_ovf[3] = if3.Overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference: true integer arithmetic, then range checks and clamping.
  function automatic logic [17:0] model(input int n, input logic [15:0] a, input logic [15:0] b,
                                        input logic op, input logic sg, input logic st);
    longint one = 1;
    longint mask, ua, ub, sa, sb, t, lo, hi;
    logic   carry, ov;
    mask = (one << n) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= (one << (n - 1))) ? ua - (one << n) : ua;
    sb = (ub >= (one << (n - 1))) ? ub - (one << n) : ub;
    carry = op ? (ua >= ub) : ((ua + ub) > mask);
    if (sg) begin
      t  = op ? sa - sb : sa + sb;
      lo = -(one << (n - 1));
      hi = (one << (n - 1)) - 1;
      ov = (t < lo) || (t > hi);
      if (ov && st) t = (t > hi) ? hi : lo;
    end else begin
      t  = op ? ua - ub : ua + ub;
      ov = (t < 0) || (t > mask);
      if (ov && st) t = (t < 0) ? 0 : mask;
    end
    return {16'(t & mask), carry, ov};
  endfunction

  function automatic logic [15:0] pick(input int n);
    logic [15:0] m = 16'((32'd1 << n) - 1);
    logic [15:0] h = 16'(32'd1 << (n - 1));
    case ($urandom_range(7))
      0: return 16'd0;
      1: return m;
      2: return h;
      3: return h - 16'd1;
      default: return 16'($urandom) & m;
    endcase
  endfunction

  // Drives one transaction on instance 0 and reports what came out and when.
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic op, input logic sg,
                        input logic st, output logic [7:0] res, output logic c, output logic ov,
                        output int lat);
    @(negedge clk);
    g_a[0] = {8'd0, a}; g_b[0] = {8'd0, b};
    g_op[0] = op; g_sg[0] = sg; g_sat[0] = st;
    g_iv[0] = 1'b1; g_or[0] = 1'b1;
    @(posedge clk);
    lat = -1; res = 8'd0; c = 1'b0; ov = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      g_iv[0] = 1'b0;
      if (g_ov[0]) begin
        lat = k; res = g_res[0][7:0]; c = g_c[0]; ov = g_ovf[0];
        break;
      end
    end
    $display("txn A=%h B=%h op=%b signed=%b sat=%b -> Result=%h Carry=%b Overflow=%b latency=%0d",
             a, b, op, sg, st, res, c, ov, lat);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (g_ov[0] !== 1'b0) $display("FAIL reset_o_valid: got %b want 0", g_ov[0]); else passes++;
    checks++; if (g_res[0] !== 16'd0) $display("FAIL reset_result: got %h want 0", g_res[0]); else passes++;
    checks++; if (g_c[0] !== 1'b0) $display("FAIL reset_carry: got %b want 0", g_c[0]); else passes++;
    checks++; if (g_ovf[0] !== 1'b0) $display("FAIL reset_overflow: got %b want 0", g_ovf[0]); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (g_ir[0] !== 1'b1) $display("FAIL reset_i_ready: got %b want 1", g_ir[0]); else passes++;
  endtask

  task automatic test_signed_overflow();
    logic [7:0] r; logic c, v; int lat;
    do_txn(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, r, c, v, lat);
    checks++; if (lat !== 3) $display("FAIL s_add_latency: got %0d want 3", lat); else passes++;
    checks++; if (r !== 8'h80) $display("FAIL s_add_wrap_result: got %h want 80", r); else passes++;
    checks++; if (v !== 1'b1) $display("FAIL s_add_wrap_overflow: got %b want 1", v); else passes++;
    checks++; if (c !== 1'b0) $display("FAIL s_add_wrap_carry: got %b want 0", c); else passes++;
    do_txn(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, r, c, v, lat);
    checks++; if (r !== 8'h7F) $display("FAIL s_add_sat_result: got %h want 7f", r); else passes++;
    checks++; if (v !== 1'b1) $display("FAIL s_add_sat_overflow: got %b want 1", v); else passes++;
  endtask

  task automatic test_unsigned();
    logic [7:0] r; logic c, v; int lat;
    do_txn(8'h00, 8'h01, 1'b1, 1'b0, 1'b0, r, c, v, lat);
    checks++; if (r !== 8'hFF) $display("FAIL u_sub_wrap_result: got %h want ff", r); else passes++;
    checks++; if (c !== 1'b0) $display("FAIL u_sub_wrap_carry: got %b want 0", c); else passes++;
    checks++; if (v !== 1'b1) $display("FAIL u_sub_wrap_overflow: got %b want 1", v); else passes++;
    do_txn(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, r, c, v, lat);
    checks++; if (r !== 8'h00) $display("FAIL u_sub_sat_result: got %h want 00", r); else passes++;
    do_txn(8'd200, 8'd100, 1'b0, 1'b0, 1'b1, r, c, v, lat);
    checks++; if (r !== 8'hFF) $display("FAIL u_add_sat_result: got %h want ff", r); else passes++;
    checks++; if (c !== 1'b1) $display("FAIL u_add_sat_carry: got %b want 1", c); else passes++;
    checks++; if (v !== 1'b1) $display("FAIL u_add_sat_overflow: got %b want 1", v); else passes++;
  endtask

  task automatic test_signed_sub();
    logic [7:0] r; logic c, v; int lat;
    do_txn(8'h80, 8'h01, 1'b1, 1'b1, 1'b1, r, c, v, lat);
    checks++; if (r !== 8'h80) $display("FAIL s_sub_sat_result: got %h want 80", r); else passes++;
    checks++; if (v !== 1'b1) $display("FAIL s_sub_sat_overflow: got %b want 1", v); else passes++;
    do_txn(8'd10, 8'd7, 1'b1, 1'b1, 1'b0, r, c, v, lat);
    checks++; if (r !== 8'd3) $display("FAIL s_sub_small_result: got %h want 03", r); else passes++;
    checks++; if (v !== 1'b0) $display("FAIL s_sub_small_overflow: got %b want 0", v); else passes++;
    checks++; if (c !== 1'b1) $display("FAIL s_sub_small_carry: got %b want 1", c); else passes++;
    do_txn(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, r, c, v, lat);
    checks++; if ({r, c, v} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL zero_minus_zero: got %h/%b/%b want 00/1/0", r, c, v); else passes++;
    do_txn(8'h00, 8'h80, 1'b1, 1'b1, 1'b1, r, c, v, lat);
    checks++; if ({r, v} !== {8'h7F, 1'b1})
      $display("FAIL zero_minus_min_sat: got %h/%b want 7f/1", r, v); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [17:0] expv [6];
    logic [17:0] snap, act;
    int sent = 0, got = 0, stall_left = -1;
    logic [7:0] ta [6];
    logic [7:0] tb_ [6];
    logic [2:0] tc [6];
    for (int i = 0; i < 6; i++) begin
      ta[i] = 8'($urandom); tb_[i] = 8'($urandom); tc[i] = 3'($urandom);
      expv[i] = model(8, {8'd0, ta[i]}, {8'd0, tb_[i]}, tc[i][0], tc[i][1], tc[i][2]);
    end
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      g_iv[0] = (sent < 6);
      if (sent < 6) begin
        g_a[0] = {8'd0, ta[sent]}; g_b[0] = {8'd0, tb_[sent]};
        g_op[0] = tc[sent][0]; g_sg[0] = tc[sent][1]; g_sat[0] = tc[sent][2];
      end
      if (stall_left < 0 && g_ov[0]) begin
        stall_left = 3;
        snap = {g_res[0], g_c[0], g_ovf[0]};
      end
      g_or[0] = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        checks++; if (g_ir[0] !== 1'b0) $display("FAIL stall_i_ready: got %b want 0", g_ir[0]); else passes++;
        if (stall_left < 3) begin
          act = {g_res[0], g_c[0], g_ovf[0]};
          checks++; if (act !== snap) $display("FAIL stall_hold: got %h want %h", act, snap); else passes++;
        end
        stall_left--;
      end
      if (g_iv[0] && g_ir[0]) sent++;
      if (g_ov[0] && g_or[0]) begin
        act = {g_res[0], g_c[0], g_ovf[0]};
        $display("txn b2b %0d: Result=%h Carry=%b Overflow=%b", got, act[17:2], act[1], act[0]);
        checks++; if (act !== expv[got]) $display("FAIL b2b_result_%0d: got %h want %h", got, act, expv[got]); else passes++;
        got++;
      end
    end
    g_iv[0] = 1'b0; g_or[0] = 1'b1;
    checks++; if (got !== 6) $display("FAIL b2b_count: got %0d want 6", got); else passes++;
  endtask

  task automatic test_async_reset();
    logic [7:0] r; logic c, v; int lat;
    int stale = 0;
    @(negedge clk);
    g_or[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      g_a[0] = 16'(i + 1); g_b[0] = 16'd2;
      g_op[0] = 1'b0; g_sg[0] = 1'b0; g_sat[0] = 1'b0; g_iv[0] = 1'b1;
      @(negedge clk);
    end
    g_iv[0] = 1'b0;
    @(negedge clk);
    checks++; if (g_ov[0] !== 1'b1) $display("FAIL pre_reset_o_valid: got %b want 1", g_ov[0]); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++; if (g_ov[0] !== 1'b0) $display("FAIL async_reset_o_valid: got %b want 0", g_ov[0]); else passes++;
    checks++; if (g_res[0] !== 16'd0) $display("FAIL async_reset_result: got %h want 0", g_res[0]); else passes++;
    @(negedge clk);
    #2 rst = 1'b1;
    g_or[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (g_ov[0]) stale++;
    end
    checks++; if (stale !== 0) $display("FAIL stale_after_reset: got %0d outputs want 0", stale); else passes++;
    do_txn(8'd5, 8'd3, 1'b0, 1'b0, 1'b0, r, c, v, lat);
    checks++; if (lat !== 3) $display("FAIL post_reset_latency: got %0d want 3", lat); else passes++;
    checks++; if (r !== 8'd8) $display("FAIL post_reset_result: got %h want 08", r); else passes++;
  endtask

  task automatic run_random(input int idx, input int n, input int ntx, input int rdy_pct);
    logic [17:0] exp_q [$];
    logic [17:0] e, act;
    int sent = 0, got = 0;
    bit acc = 1'b0;
    for (int cyc = 0; cyc < ntx * 8 && got < ntx; cyc++) begin
      @(negedge clk);
      if (acc) g_iv[idx] = 1'b0;
      acc = 1'b0;
      if (!g_iv[idx] && sent < ntx && $urandom_range(3) != 0) begin
        g_a[idx] = pick(n); g_b[idx] = pick(n);
        g_op[idx] = 1'($urandom); g_sg[idx] = 1'($urandom); g_sat[idx] = 1'($urandom);
        g_iv[idx] = 1'b1;
      end
      g_or[idx] = (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (g_iv[idx] && g_ir[idx]) begin
        exp_q.push_back(model(n, g_a[idx], g_b[idx], g_op[idx], g_sg[idx], g_sat[idx]));
        sent++;
        acc = 1'b1;
      end
      if (g_ov[idx] && g_or[idx]) begin
        act = {g_res[idx], g_c[idx], g_ovf[idx]};
        $display("txn cfg%0d #%0d: Result=%h Carry=%b Overflow=%b", idx, got, act[17:2], act[1], act[0]);
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL cfg%0d_spurious: got output %h want none", idx, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) $display("FAIL cfg%0d_txn%0d: got %h want %h", idx, got, act, e);
          else passes++;
        end
        got++;
      end
    end
    g_iv[idx] = 1'b0;
    checks++;
    if (got !== ntx || exp_q.size() != 0)
      $display("FAIL cfg%0d_count: got %0d outputs want %0d", idx, got, ntx);
    else passes++;
  endtask

  task automatic test_random_main();
    run_random(0, 8, 300, 70);
  endtask

  task automatic test_param_sweep();
    fork
      run_random(1, 8, 10000, 75);
      run_random(2, 13, 10000, 75);
      run_random(3, 3, 10000, 75);
    join
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g_a[i] = '0; g_b[i] = '0; g_op[i] = 1'b0; g_sg[i] = 1'b0; g_sat[i] = 1'b0;
      g_iv[i] = 1'b0; g_or[i] = 1'b1;
    end
    test_reset();
    test_signed_overflow();
    test_unsigned();
    test_signed_sub();
    test_back_to_back();
    test_async_reset();
    test_random_main();
    test_param_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
